// File: rtl/norm_row_sequencer_if.sv
// Bundle of signals between the norm row sequencer, its row source/sink and the norm stage.
// Both row handshakes: a transfer happens on a clock edge where valid and ready are both high;
// valid, once raised, holds with stable data until that edge, and ready never waits on valid.
interface norm_row_sequencer_if #(
    parameter int bw  = 4,
    parameter int col = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [col*bw-1:0]     in_row;
    logic                  norm_clr;
    logic                  norm_wr;
    logic [bw-1:0]         norm_in;
    logic                  norm_div;
    logic                  norm_full;
    logic [2*bw-1:0]       norm_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [col*2*bw-1:0]   out_row;
    logic [2:0]            state_dbg;

    modport master (
        input  in_valid, in_row, norm_full, norm_out, out_ready,
        output in_ready, norm_clr, norm_wr, norm_in, norm_div, out_valid, out_row, state_dbg
    );

    modport slave (
        output in_valid, in_row, norm_full, norm_out, out_ready,
        input  in_ready, norm_clr, norm_wr, norm_in, norm_div, out_valid, out_row, state_dbg
    );
endinterface

// File: rtl/norm_row_sequencer.sv
// Serialises a parallel psum row into the norm stage, issues the divide pulses and
// gathers the normalised results back into a parallel row for the downstream consumer.
module norm_row_sequencer #(
    parameter int bw  = 4,
    parameter int col = 8
) (
    input logic                   clk,
    input logic                   reset,
    norm_row_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        DIV   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int kw = $clog2(col);
    localparam logic [kw-1:0] k_last = kw'(col - 1);

    state_t                state;
    logic [kw-1:0]         k;
    logic [col*bw-1:0]     row_q;
    logic [col*2*bw-1:0]   out_row_q;
    logic                  out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            row_q       <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        row_q <= bus.in_row;
                        // An all-zero row would make norm divide by zero, so answer it directly.
                        if (bus.in_row == '0) begin
                            out_row_q   <= '0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CLR;
                        end
                    end
                end
                CLR: begin
                    k     <= '0;
                    state <= LOAD;
                end
                LOAD: begin
                    if (!bus.norm_full) begin
                        if (k == k_last) begin
                            k     <= '0;
                            state <= DIV;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                DIV: begin
                    // norm_out lags its div pulse by one cycle, hence the k-1 slot.
                    if (k != '0)
                        out_row_q[(int'(k) - 1)*2*bw +: 2*bw] <= bus.norm_out;
                    if (k == k_last) begin
                        state <= DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    out_row_q[(col - 1)*2*bw +: 2*bw] <= bus.norm_out;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.norm_clr  = reset | (state == CLR);
    assign bus.norm_wr   = (state == LOAD) & ~bus.norm_full;
    assign bus.norm_in   = row_q[int'(k)*bw +: bw];
    assign bus.norm_div  = (state == DIV);
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_norm_row_sequencer.sv
// Bench for norm_row_sequencer paired with a behavioural norm stage (abs, running sum, FIFO, divide).
module tb_norm_row_sequencer;
  localparam int bw  = 4;
  localparam int col = 4;

  logic clk = 1'b0;
  logic reset;

  norm_row_sequencer_if #(.bw(bw), .col(col)) bus ();

  norm_row_sequencer #(.bw(bw), .col(col)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int abs4(input logic [3:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? -v : v;
  endfunction

  // reference: each result is |e|*2^(2*bw)/sum|e|, truncated to 2*bw bits; all-zero row gives 0
  function automatic logic [31:0] ref_row(input logic [15:0] r);
    int a [col];
    int s;
    logic [31:0] res;
    s = 0;
    res = '0;
    for (int i = 0; i < col; i++) begin
      a[i] = abs4(r[i*bw +: bw]);
      s += a[i];
    end
    if (s != 0)
      for (int i = 0; i < col; i++) res[i*8 +: 8] = 8'((a[i] * 256) / s);
    return res;
  endfunction

  // behavioural norm stage partner
  int m_sum = 0;
  logic [3:0] m_fifo[$];
  logic [3:0] m_e;
  always @(posedge clk) begin
    if (bus.norm_clr) begin
      m_sum = 0;
      m_fifo.delete();
    end else begin
      if (bus.norm_wr) begin
        m_fifo.push_back(bus.norm_in);
        m_sum += abs4(bus.norm_in);
      end
      if (bus.norm_div) begin
        if (m_fifo.size() > 0 && m_sum > 0) begin
          m_e = m_fifo.pop_front();
          bus.norm_out <= 8'((abs4(m_e) * 256) / m_sum);
        end else begin
          bus.norm_out <= '0;
        end
      end
    end
  end

  // scoreboard: element write order into norm
  logic [bw-1:0] exp_q[$];
  int wr_cnt = 0;
  int div_cnt = 0;
  int clr_cnt = 0;
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.norm_wr) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
        else check("wr_order", 32'(bus.norm_in), 32'(exp_q.pop_front()));
      end
      if (bus.norm_div) div_cnt++;
      if (bus.norm_clr) clr_cnt++;
    end
  end

  task automatic start_row(input logic [15:0] row);
    exp_q.delete();
    if (row != '0)
      for (int i = 0; i < col; i++) exp_q.push_back(row[i*bw +: bw]);
    wr_cnt = 0;
    div_cnt = 0;
    clr_cnt = 0;
  endtask

  // driver: one row end-to-end with optional norm_full stall and downstream hold-off
  task automatic send_row(input logic [15:0] row, input int stall_at, input int stall_len,
                          input int hold, input string tag, output logic [31:0] got);
    int w;
    int lat;
    int full_left;
    int eff_stall;
    bit stalled;
    logic [31:0] exp_row;
    exp_row = ref_row(row);
    eff_stall = (row == '0) ? 0 : stall_len;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    start_row(row);
    bus.in_row = row;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    full_left = 0;
    stalled = 0;
    while (!bus.out_valid && lat < 200) begin
      if (!stalled && eff_stall > 0 && wr_cnt == stall_at) begin
        bus.norm_full = 1'b1;
        full_left = eff_stall;
        stalled = 1;
      end
      @(posedge clk); #1; lat++;
      if (full_left > 0) begin
        full_left--;
        if (full_left == 0) bus.norm_full = 1'b0;
      end
    end
    bus.norm_full = 1'b0;
    check({tag, "_latency"}, 32'(lat), (row == '0) ? 32'd1 : 32'(2*col + 3 + eff_stall));
    got = bus.out_row;
    check({tag, "_row"}, bus.out_row, exp_row);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), (row == '0) ? 32'd0 : 32'(col));
    check({tag, "_div_cnt"}, 32'(div_cnt), (row == '0) ? 32'd0 : 32'(col));
    check({tag, "_clr_cnt"}, 32'(clr_cnt), (row == '0) ? 32'd0 : 32'd1);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_row = ~row;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_row"}, bus.out_row, exp_row);
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  logic [31:0] res;
  logic [15:0] r;
  int w;

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_row = '0;
    bus.norm_full = 1'b0;
    bus.out_ready = 1'b0;
    bus.norm_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_row", bus.out_row, 32'd0);
    check("rst_norm_clr", 32'(bus.norm_clr), 32'd1);
    check("rst_norm_wr", 32'(bus.norm_wr), 32'd0);
    check("rst_norm_div", 32'(bus.norm_div), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_norm_clr", 32'(bus.norm_clr), 32'd0);

    // directed rows; elem0 sits in the low nibble
    send_row(16'h2321, 0, 0, 0, "t1", res);
    check("t1_const", res, 32'h40604020);
    send_row(16'h2e1f, 0, 0, 0, "t2", res);
    check("t2_const", res, 32'h55552a2a);
    send_row(16'h0000, 0, 0, 0, "t3", res);
    check("t3_const", res, 32'h0);
    send_row(16'h2321, 2, 3, 0, "t4", res);
    check("t4_const", res, 32'h40604020);
    send_row(16'h8123, 0, 0, 5, "t5a", res);
    send_row(16'h1111, 0, 0, 0, "t5b", res);
    check("t5b_const", res, 32'h40404040);

    // reset while dividing with k=2
    start_row(16'h2321);
    bus.in_row = 16'h2321;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    w = 0;
    while (div_cnt < 2 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("t6_in_div", 32'(bus.norm_div), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_idle", 32'(bus.in_ready), 32'd1);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_out_row", bus.out_row, 32'd0);
    send_row(16'h2321, 0, 0, 0, "t6", res);
    check("t6_const", res, 32'h40604020);

    // randomized rows, stalls and hold-offs
    for (int n = 0; n < 24; n++) begin
      int sa, sl, hd;
      r = '0;
      if ($urandom_range(0, 5) != 0)
        for (int i = 0; i < col; i++) r[i*bw +: bw] = 4'($urandom_range(0, 15));
      sa = $urandom_range(1, col - 1);
      sl = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : 0;
      hd = $urandom_range(0, 3);
      send_row(r, sa, sl, hd, "rnd", res);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
